// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 fp16 convolution datapath.
//   fp16_t         : raw IEEE half-precision word
//   KERNEL_SIZE    : window size supported by the conv adder tree
//   feeder_state_t : column-stream feeder FSM states
package conv_pkg;

  localparam int KERNEL_SIZE = 3;

  typedef logic [15:0] fp16_t;

  typedef enum logic [2:0] {
    IDLE,
    W_IN,
    K_SEND,
    PRIME,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// Ring of LINES image lines, WIDTH words each.
//   clk     : clock
//   wr_en   : write wr_data into line ptr, slot x
//   ptr     : ring pointer; names the oldest line, which is also the one overwritten
//   x       : shared column index for the write port and all read ports
//   wr_data : word to write
//   rd_data : lane l returns line (ptr + l) mod LINES at slot x, oldest first
// Reads are combinational, so a read and a write to the same slot in one
// cycle return the old word (read-before-write).
module conv_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int LINES      = 2,
  parameter int WIDTH      = 28,
  localparam int XW        = $clog2(WIDTH),
  localparam int PW        = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic                              clk,
  input  logic                              wr_en,
  input  logic [PW-1:0]                     ptr,
  input  logic [XW-1:0]                     x,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic [LINES-1:0][DATA_WIDTH-1:0]  rd_data
);

  logic [DATA_WIDTH-1:0] mem [LINES][WIDTH];

  function automatic logic [PW-1:0] ring_add(input logic [PW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= LINES) s = s - LINES;
    return PW'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr][x] <= wr_data;
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_rd
    logic [PW-1:0] line_idx;
    assign line_idx    = ring_add(ptr, gi);
    assign rd_data[gi] = mem[line_idx][x];
  end

endmodule

// File: rtl/conv_3_feeder.sv
// Initiator side of the 3x3 fp16 conv unit's column-stream interface.
// Loads a row-major kernel, sends it as K column beats, then turns a
// row-major pixel stream into K-lane image column beats using a K-1 line
// buffer, and produces the conv unit's capture / result timing.
//   clk, rst              : clock, asynchronous active-high reset
//   start, busy, done     : frame control (start ignored while busy)
//   w_valid/w_ready/w_data    : weight stream, W[r][c] row-major
//   px_valid/px_ready/px_data : pixel stream, P[y][x] row-major
//   conv_data             : column beat, lane l = row offset l
//   conv_kernel_load      : beat carries kernel weights
//   conv_valid_in         : beat strobe
//   conv_valid_out        : tells the conv unit to latch its output
//   res_valid/res_x/res_y : conv output is new, with its output coordinates
module conv_3_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  input  logic [DATA_WIDTH-1:0]                  w_data,
  input  logic                                   px_valid,
  output logic                                   px_ready,
  input  logic [DATA_WIDTH-1:0]                  px_data,
  output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] conv_data,
  output logic                                   conv_kernel_load,
  output logic                                   conv_valid_in,
  output logic                                   conv_valid_out,
  output logic                                   res_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]           res_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]          res_y
);
  import conv_pkg::*;

  localparam int K   = KERNEL_SIZE;
  localparam int KK  = K * K;
  localparam int L   = K - 1;
  localparam int XW  = $clog2(IMG_WIDTH);
  localparam int YW  = $clog2(IMG_HEIGHT);
  localparam int PW  = (L > 1) ? $clog2(L) : 1;
  localparam int WCW = $clog2(KK);
  localparam int KCW = $clog2(K);

  feeder_state_t state_reg, state_next;

  logic [WCW-1:0] w_cnt_reg;
  logic [KCW-1:0] k_cnt_reg;
  logic [XW-1:0]  x_reg;
  logic [YW-1:0]  y_reg;
  logic [PW-1:0]  ptr_reg;
  logic [PW-1:0]  ptr_inc;

  logic [DATA_WIDTH-1:0] w_reg [KK];

  logic [L-1:0][DATA_WIDTH-1:0] lb_rd;
  logic [K-1:0][DATA_WIDTH-1:0] kernel_lanes;
  logic [K-1:0][DATA_WIDTH-1:0] stream_lanes;

  logic                         beat_fire;
  logic                         beat_kload;
  logic                         beat_cap;
  logic [K-1:0][DATA_WIDTH-1:0] beat_data;
  logic [XW-1:0]                cap_x;
  logic [YW-1:0]                cap_y;

  logic last_col, last_row, final_res;

  // Output pipeline: beat -> capture command -> result strobe.
  logic [K-1:0][DATA_WIDTH-1:0] conv_data_reg;
  logic                         conv_kernel_load_reg;
  logic                         conv_valid_in_reg;
  logic                         cap1_reg;
  logic [XW-1:0]                rx1_reg, rx2_reg, res_x_reg;
  logic [YW-1:0]                ry1_reg, ry2_reg, res_y_reg;
  logic                         conv_valid_out_reg;
  logic                         res_valid_reg;
  logic                         done_reg;

  assign last_col = (x_reg == XW'(IMG_WIDTH - 1));
  assign last_row = (y_reg == YW'(IMG_HEIGHT - 1));
  assign ptr_inc  = (ptr_reg == PW'(L - 1)) ? '0 : ptr_reg + 1'b1;
  // Rows are counted from the top of the image; output row lags by K-1.
  assign cap_y    = y_reg - YW'(L);
  assign final_res = res_valid_reg
                   && (res_x_reg == XW'(IMG_WIDTH - K))
                   && (res_y_reg == YW'(IMG_HEIGHT - K));

  // Kernel beat c carries column c of the weights: lane l = W[l][c].
  // Image beat: lanes 0..K-2 from the buffered lines (oldest first), top lane live.
  for (genvar gi = 0; gi < K; gi++) begin : g_lanes
    assign kernel_lanes[gi] = w_reg[WCW'(gi * K) + WCW'(k_cnt_reg)];
    if (gi < L) begin : g_buf
      assign stream_lanes[gi] = lb_rd[gi];
    end else begin : g_live
      assign stream_lanes[gi] = px_data;
    end
  end

  conv_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINES      (L),
    .WIDTH      (IMG_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (px_ready && px_valid),
    .ptr     (ptr_reg),
    .x       (x_reg),
    .wr_data (px_data),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    w_ready    = 1'b0;
    px_ready   = 1'b0;
    beat_fire  = 1'b0;
    beat_kload = 1'b0;
    beat_cap   = 1'b0;
    beat_data  = '0;
    cap_x      = '0;
    unique case (state_reg)
      IDLE: begin
        if (start) state_next = W_IN;
      end
      W_IN: begin
        w_ready = 1'b1;
        if (w_valid && (w_cnt_reg == WCW'(KK - 1))) state_next = K_SEND;
      end
      K_SEND: begin
        beat_fire  = 1'b1;
        beat_kload = 1'b1;
        beat_data  = kernel_lanes;
        if (k_cnt_reg == KCW'(K - 1)) state_next = PRIME;
      end
      PRIME: begin
        px_ready = 1'b1;
        if (px_valid && last_col && (y_reg == YW'(L - 1))) state_next = STREAM;
      end
      STREAM: begin
        px_ready = 1'b1;
        if (px_valid) begin
          beat_fire = 1'b1;
          beat_data = stream_lanes;
          // Beat n completes the window ending at column n-1.
          if (x_reg >= XW'(K)) begin
            beat_cap = 1'b1;
            cap_x    = x_reg - XW'(K);
          end
          if (last_col) state_next = FLUSH;
        end
      end
      FLUSH: begin
        // Zero beat acts as column n = IMG_WIDTH; always a capture beat.
        beat_fire  = 1'b1;
        beat_cap   = 1'b1;
        cap_x      = XW'(IMG_WIDTH - K);
        state_next = last_row ? DONE : STREAM;
      end
      DONE: begin
        if (final_res) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cnt_reg <= '0;
      k_cnt_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      ptr_reg   <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            w_cnt_reg <= '0;
            k_cnt_reg <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            ptr_reg   <= '0;
          end
        end
        W_IN: begin
          if (w_valid) w_cnt_reg <= (w_cnt_reg == WCW'(KK - 1)) ? '0 : w_cnt_reg + 1'b1;
        end
        K_SEND: begin
          k_cnt_reg <= (k_cnt_reg == KCW'(K - 1)) ? '0 : k_cnt_reg + 1'b1;
        end
        PRIME: begin
          if (px_valid) begin
            if (last_col) begin
              x_reg   <= '0;
              y_reg   <= y_reg + 1'b1;
              ptr_reg <= ptr_inc;
            end else begin
              x_reg <= x_reg + 1'b1;
            end
          end
        end
        STREAM: begin
          if (px_valid) x_reg <= last_col ? '0 : x_reg + 1'b1;
        end
        FLUSH: begin
          // Row pointer advances only once the row's flush beat is out, so
          // every beat of the row sees the same line ordering.
          if (!last_row) begin
            y_reg   <= y_reg + 1'b1;
            ptr_reg <= ptr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Kernel words; contents are meaningless until a frame loads them.
  always_ff @(posedge clk) begin
    if ((state_reg == W_IN) && w_valid) w_reg[w_cnt_reg] <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_data_reg        <= '0;
      conv_kernel_load_reg <= 1'b0;
      conv_valid_in_reg    <= 1'b0;
      cap1_reg             <= 1'b0;
      rx1_reg              <= '0;
      ry1_reg              <= '0;
      conv_valid_out_reg   <= 1'b0;
      rx2_reg              <= '0;
      ry2_reg              <= '0;
      res_valid_reg        <= 1'b0;
      res_x_reg            <= '0;
      res_y_reg            <= '0;
      done_reg             <= 1'b0;
    end else begin
      conv_data_reg        <= beat_data;
      conv_kernel_load_reg <= beat_kload;
      conv_valid_in_reg    <= beat_fire;
      cap1_reg             <= beat_fire && beat_cap;
      rx1_reg              <= cap_x;
      ry1_reg              <= cap_y;
      conv_valid_out_reg   <= cap1_reg;
      rx2_reg              <= rx1_reg;
      ry2_reg              <= ry1_reg;
      res_valid_reg        <= conv_valid_out_reg;
      if (conv_valid_out_reg) begin
        res_x_reg <= rx2_reg;
        res_y_reg <= ry2_reg;
      end
      done_reg <= (state_reg == DONE) && final_res;
    end
  end

  assign busy             = (state_reg != IDLE);
  assign done             = done_reg;
  assign conv_data        = conv_data_reg;
  assign conv_kernel_load = conv_kernel_load_reg;
  assign conv_valid_in    = conv_valid_in_reg;
  assign conv_valid_out   = conv_valid_out_reg;
  assign res_valid        = res_valid_reg;
  assign res_x            = res_x_reg;
  assign res_y            = res_y_reg;

endmodule

// File: tb/tb_conv_3_feeder.sv
module tb_conv_3_feeder;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, busy, done;
  logic                 w_valid, w_ready, px_valid, px_ready;
  logic [DW-1:0]        w_data, px_data;
  logic [K-1:0][DW-1:0] conv_data;
  logic                 conv_kernel_load, conv_valid_in, conv_valid_out, res_valid;
  logic [XW-1:0]        res_x;
  logic [YW-1:0]        res_y;

  conv_3_feeder #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .w_valid          (w_valid),
    .w_ready          (w_ready),
    .w_data           (w_data),
    .px_valid         (px_valid),
    .px_ready         (px_ready),
    .px_data          (px_data),
    .conv_data        (conv_data),
    .conv_kernel_load (conv_kernel_load),
    .conv_valid_in    (conv_valid_in),
    .conv_valid_out   (conv_valid_out),
    .res_valid        (res_valid),
    .res_x            (res_x),
    .res_y            (res_y)
  );

  typedef struct packed {
    logic [K*DW-1:0] d;
    logic            k;
    logic            cap;
  } beat_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } res_t;

  beat_t exp_beats[$];
  res_t  exp_res[$];

  int checks = 0;
  int errors = 0;

  conv_pkg::fp16_t wts[K*K];
  conv_pkg::fp16_t pix[W*H];

  int              beat_cnt, res_cnt;
  logic            got_k, got_s;
  logic [K*DW-1:0] first_k, first_s;
  logic [5:0]      first_r, last_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Small non-negative integer to fp16 (exact for n < 2048).
  function automatic conv_pkg::fp16_t int_to_fp16(input int n);
    int e;
    if (n == 0) return 16'h0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return 16'((e + 15) << 10) | 16'((n << (10 - e)) & 'h3FF);
  endfunction

  // Expected beats and results straight from the frame definition.
  task automatic build_model();
    beat_t b;
    res_t  r;
    for (int c = 0; c < K; c++) begin
      b.d   = {wts[2*K + c], wts[K + c], wts[c]};
      b.k   = 1'b1;
      b.cap = 1'b0;
      exp_beats.push_back(b);
    end
    for (int y = K - 1; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        b.d   = {pix[y*W + x], pix[(y-1)*W + x], pix[(y-2)*W + x]};
        b.k   = 1'b0;
        b.cap = (x >= K);
        exp_beats.push_back(b);
      end
      b.d   = '0;
      b.k   = 1'b0;
      b.cap = 1'b1;
      exp_beats.push_back(b);
    end
    for (int y = 0; y <= H - K; y++)
      for (int x = 0; x <= W - K; x++) begin
        r.x = XW'(x);
        r.y = YW'(y);
        exp_res.push_back(r);
      end
  endtask

  // Compare process: runs every cycle, 1 time unit after the active edge.
  initial begin : cmp
    logic  prev_cap, prev2_cap, done_due, cur_cap;
    beat_t e;
    res_t  r;
    prev_cap  = 1'b0;
    prev2_cap = 1'b0;
    done_due  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_cap  = 1'b0;
        prev2_cap = 1'b0;
        done_due  = 1'b0;
        continue;
      end
      check("ready_exclusive", 64'(w_ready && px_ready), 64'd0);
      cur_cap = 1'b0;
      if (conv_valid_in) begin
        beat_cnt++;
        if (!got_k) begin got_k = 1'b1; first_k = conv_data; end
        if (!conv_kernel_load && !got_s) begin got_s = 1'b1; first_s = conv_data; end
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got beat 0x%0h, expected none", conv_data);
        end else begin
          e = exp_beats.pop_front();
          check("beat_data", 64'(conv_data), 64'(e.d));
          check("beat_kload", 64'(conv_kernel_load), 64'(e.k));
          cur_cap = e.cap;
        end
      end
      check("valid_out", 64'(conv_valid_out), 64'(prev_cap));
      check("res_valid", 64'(res_valid), 64'(prev2_cap));
      check("done", 64'(done), 64'(done_due));
      done_due = 1'b0;
      if (res_valid) begin
        res_cnt++;
        if (res_cnt == 1) first_r = {res_x, res_y};
        last_r = {res_x, res_y};
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_result: got (%0d,%0d), expected none", res_x, res_y);
        end else begin
          r = exp_res.pop_front();
          check("res_x", 64'(res_x), 64'(r.x));
          check("res_y", 64'(res_y), 64'(r.y));
          if (exp_res.size() == 0) done_due = 1'b1;
        end
      end
      prev2_cap = prev_cap;
      prev_cap  = cur_cap;
    end
  end

  function automatic logic want_valid(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return cyc[0];
    return ($urandom_range(0, 99) >= 30);
  endfunction

  // mode: 0 no stalls, 1 valid every other cycle, 2 random stalls.
  // stop_px < 0 runs the full frame and waits for done.
  task automatic run_frame(input int mode, input bit inject_start, input int stop_px);
    int idx, cyc, limit;
    beat_cnt = 0;
    res_cnt  = 0;
    got_k    = 1'b0;
    got_s    = 1'b0;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);

    idx = 0;
    cyc = 0;
    while (idx < K*K && cyc < 500) begin
      w_valid = want_valid(mode, cyc);
      w_data  = wts[idx];
      if (w_valid && w_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    w_valid = 1'b0;
    check("weights_accepted", 64'(idx), 64'(K*K));

    limit = (stop_px < 0) ? W*H : stop_px;
    idx = 0;
    cyc = 0;
    while (idx < limit && cyc < 2000) begin
      start    = inject_start && (idx == 12);
      px_valid = want_valid(mode, cyc);
      px_data  = pix[idx];
      if (px_valid && px_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    px_valid = 1'b0;
    check("pixels_accepted", 64'(idx), 64'(limit));

    if (stop_px < 0) begin
      cyc = 0;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("busy_low_at_done", 64'(busy), 64'd0);
      check("beats_left", 64'(exp_beats.size()), 64'd0);
      check("results_left", 64'(exp_res.size()), 64'd0);
      check("result_count", 64'(res_cnt), 64'd9);
      check("beat_count", 64'(beat_cnt), 64'd21);
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_w_ready"}, 64'(w_ready), 64'd0);
    check({tag, "_px_ready"}, 64'(px_ready), 64'd0);
    check({tag, "_conv_data"}, 64'(conv_data), 64'd0);
    check({tag, "_kload"}, 64'(conv_kernel_load), 64'd0);
    check({tag, "_valid_in"}, 64'(conv_valid_in), 64'd0);
    check({tag, "_valid_out"}, 64'(conv_valid_out), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_xy"}, 64'({res_x, res_y}), 64'd0);
  endtask

  task automatic random_frame_data();
    for (int i = 0; i < K*K; i++) wts[i] = 16'($urandom);
    for (int i = 0; i < W*H; i++) pix[i] = 16'($urandom);
  endtask

  initial begin : main
    rst      = 1'b1;
    start    = 1'b0;
    w_valid  = 1'b0;
    px_valid = 1'b0;
    w_data   = '0;
    px_data  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Frame A: weights 1..9, P[y][x] = y*5+x, no stalls.
    for (int i = 0; i < K*K; i++) wts[i] = int_to_fp16(i + 1);
    for (int i = 0; i < W*H; i++) pix[i] = int_to_fp16(i);
    run_frame(0, 1'b0, -1);
    $display("frame A: %0d beats, %0d results", beat_cnt, res_cnt);
    check("pin_kernel_beat0", 64'(first_k), 64'h4700_4400_3C00);
    check("pin_stream_beat0", 64'(first_s), 64'h4900_4500_0000);
    check("pin_first_result", 64'(first_r), 64'({3'd0, 3'd0}));
    check("pin_last_result", 64'(last_r), 64'({3'd2, 3'd2}));

    // Frame B: same frame, pixel/weight valid every other cycle.
    run_frame(1, 1'b0, -1);
    $display("frame B: %0d beats, %0d results", beat_cnt, res_cnt);
    check("pin_b_stream_beat0", 64'(first_s), 64'h4900_4500_0000);

    // Frame C: identity kernel, random stalls, start pulsed while busy.
    for (int i = 0; i < K*K; i++) wts[i] = (i == 4) ? 16'h3C00 : 16'h0000;
    run_frame(2, 1'b1, -1);
    $display("frame C: %0d beats, %0d results", beat_cnt, res_cnt);
    check("pin_identity_beat0", 64'(first_k), 64'h0);
    check("busy_after_ignored_start", 64'(busy), 64'd0);

    // Frame D: abandoned by reset in the middle of streaming.
    random_frame_data();
    run_frame(2, 1'b0, 14);
    check("busy_mid_stream", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_beats.delete();
    exp_res.delete();
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("no_done_after_abort", 64'(done), 64'd0);
    $display("frame D: aborted by reset");

    // Random frames after the abort.
    for (int f = 0; f < 3; f++) begin
      random_frame_data();
      run_frame(2, f[0], -1);
      $display("frame R%0d: %0d beats, %0d results", f, beat_cnt, res_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
